// File: rtl/mo_adder_pkg.sv
// Shared definitions for the adder reduction tree.
// Holds the FSM state encoding and the width helpers used to size ports and registers.
package mo_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_HOLD
    } state_e;

    // The sum of M terms of N+1 bits needs clog2(M) extra bits so it never wraps.
    function automatic int acc_width(input int n, input int m);
        return n + 1 + $clog2(m);
    endfunction

    function automatic int cnt_width(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/mo_sum_if.sv
// Valid/ready stream bundle for the sum accumulator.
// Adder beats come in on the in_* side, and finished group totals leave on the out_* side.
interface mo_sum_if import mo_adder_pkg::*; #(
    parameter int N = 4,
    parameter int M = 4
);
    localparam int ACC_W = acc_width(N, M);
    localparam int CNT_W = cnt_width(M);

    logic             in_valid;
    logic             in_ready;
    logic [N:0]       in_sum;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_err;

    modport slave (
        input  in_valid, in_sum, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_err
    );

    modport master (
        output in_valid, in_sum, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_err
    );

endinterface

// File: rtl/mo_out_slot.sv
// One-deep output holding register with a valid/ready handshake.
// A load takes priority over a consume, so the slot can be refilled in the same cycle it drains.
module mo_out_slot #(
    parameter int ACC_W = 7,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [ACC_W-1:0] sum_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             err_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic             in_ready_o,
    output logic [ACC_W-1:0] sum_o,
    output logic [CNT_W-1:0] count_o,
    output logic             err_o
);

    logic             valid_q;
    logic [ACC_W-1:0] sum_q;
    logic [CNT_W-1:0] count_q;
    logic             err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            sum_q   <= sum_i;
            count_q <= count_i;
            err_q   <= err_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    // Upstream may push whenever the slot is empty or is being drained this cycle.
    assign in_ready_o = !valid_q | ready_i;
    assign valid_o    = valid_q;
    assign sum_o      = sum_q;
    assign count_o    = count_q;
    assign err_o      = err_q;

endmodule

// File: rtl/mo_sum_accumulator.sv
// Sums groups of up to M adder results {cout,s} into one wide total for each group.
// A group closes on in_last or at its M-th term. The finished total waits in mo_out_slot until the consumer takes it.
module mo_sum_accumulator import mo_adder_pkg::*; #(
    parameter int N = 4,
    parameter int M = 4
) (
    input  logic   clk,
    input  logic   rst,
    mo_sum_if.slave bus
);

    localparam int ACC_W = acc_width(N, M);
    localparam int CNT_W = cnt_width(M);

    state_e           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;

    logic             in_fire;
    logic             out_fire;
    logic             close;
    logic             load;
    logic             err_d;
    logic [ACC_W-1:0] acc_d;
    logic [CNT_W-1:0] cnt_d;

    assign in_fire  = bus.in_valid & bus.in_ready;
    assign out_fire = bus.out_valid & bus.out_ready;
    assign close    = bus.in_last | (cnt_q == CNT_W'(M - 1));
    assign err_d    = close & !bus.in_last;
    assign load     = in_fire & close;
    // A zero count means acc holds no live partial sum, so the first term starts from zero.
    assign acc_d    = ((cnt_q == '0) ? '0 : acc_q) + ACC_W'(bus.in_sum);
    assign cnt_d    = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            if (in_fire) begin
                acc_q <= close ? '0 : acc_d;
                cnt_q <= close ? '0 : cnt_d;
            end
            if (load)
                state_q <= ST_HOLD;
            else if (state_q == ST_HOLD && !out_fire)
                state_q <= ST_HOLD;
            else if (in_fire || cnt_q != '0)
                state_q <= ST_ACC;
            else
                state_q <= ST_IDLE;
        end
    end

    mo_out_slot #(
        .ACC_W(ACC_W),
        .CNT_W(CNT_W)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .sum_i     (acc_d),
        .count_i   (cnt_d),
        .err_i     (err_d),
        .ready_i   (bus.out_ready),
        .valid_o   (bus.out_valid),
        .in_ready_o(bus.in_ready),
        .sum_o     (bus.out_sum),
        .count_o   (bus.out_count),
        .err_o     (bus.out_err)
    );

endmodule

// File: tb/tb_mo_sum_accumulator.sv
// Directed bench for mo_sum_accumulator with N=4 and M=4.
// Each scenario task drives its own beats and compares the outputs against hand-computed totals.
module tb_mo_sum_accumulator;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;
    int   fires7 = 0;

    mo_sum_if #(.N(4), .M(4)) bus ();

    mo_sum_accumulator #(.N(4), .M(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Counts how many times the result 7 is handed to the consumer.
    always @(posedge clk)
        if (bus.out_valid && bus.out_ready && bus.out_sum == 7'd7)
            fires7++;

    task automatic applyStimulus(input logic v, input logic [4:0] s, input logic l);
        bus.in_valid = v;
        bus.in_sum   = s;
        bus.in_last  = l;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        applyStimulus(1'b0, 5'd0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid got %0d want 0", bus.out_valid); end
        checks++; if (bus.out_sum !== 7'd0) begin fails++; $display("[TB] FAIL reset_sum got %0d want 0", bus.out_sum); end
        checks++; if (bus.out_count !== 3'd0) begin fails++; $display("[TB] FAIL reset_count got %0d want 0", bus.out_count); end
        checks++; if (bus.out_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_err got %0d want 0", bus.out_err); end
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready got %0d want 1", bus.in_ready); end
    endtask

    task automatic test_group_last();
        applyStimulus(1'b1, 5'd14, 1'b0); tick();
        applyStimulus(1'b1, 5'd23, 1'b0); tick();
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL last_early_valid got %0d want 0", bus.out_valid); end
        applyStimulus(1'b1, 5'd7, 1'b1); tick();
        checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("[TB] FAIL last_valid got %0d want 1", bus.out_valid); end
        checks++; if (bus.out_sum !== 7'd44) begin fails++; $display("[TB] FAIL last_sum got %0d want 44", bus.out_sum); end
        checks++; if (bus.out_count !== 3'd3) begin fails++; $display("[TB] FAIL last_count got %0d want 3", bus.out_count); end
        checks++; if (bus.out_err !== 1'b0) begin fails++; $display("[TB] FAIL last_err got %0d want 0", bus.out_err); end
        applyStimulus(1'b0, 5'd0, 1'b0); tick();
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL last_drain got %0d want 0", bus.out_valid); end
    endtask

    task automatic test_max_close();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'd31, 1'b0);
            tick();
        end
        checks++; if (bus.out_sum !== 7'd124) begin fails++; $display("[TB] FAIL max_sum got %0d want 124", bus.out_sum); end
        checks++; if (bus.out_count !== 3'd4) begin fails++; $display("[TB] FAIL max_count got %0d want 4", bus.out_count); end
        checks++; if (bus.out_err !== 1'b1) begin fails++; $display("[TB] FAIL max_err got %0d want 1", bus.out_err); end
        applyStimulus(1'b1, 5'd2, 1'b1); tick();
        checks++; if (bus.out_sum !== 7'd2) begin fails++; $display("[TB] FAIL fresh_sum got %0d want 2", bus.out_sum); end
        checks++; if (bus.out_count !== 3'd1) begin fails++; $display("[TB] FAIL fresh_count got %0d want 1", bus.out_count); end
        checks++; if (bus.out_err !== 1'b0) begin fails++; $display("[TB] FAIL fresh_err got %0d want 0", bus.out_err); end
        applyStimulus(1'b0, 5'd0, 1'b0); tick();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 5'd5, 1'b1); tick();
        checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("[TB] FAIL bp_valid got %0d want 1", bus.out_valid); end
        applyStimulus(1'b1, 5'd6, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("[TB] FAIL bp_in_ready got %0d want 0", bus.in_ready); end
            checks++; if (bus.out_sum !== 7'd5) begin fails++; $display("[TB] FAIL bp_hold_sum got %0d want 5", bus.out_sum); end
            tick();
        end
        checks++; if (bus.out_count !== 3'd1) begin fails++; $display("[TB] FAIL bp_count got %0d want 1", bus.out_count); end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL bp_release_ready got %0d want 1", bus.in_ready); end
        tick();
        checks++; if (bus.out_sum !== 7'd6) begin fails++; $display("[TB] FAIL bp_next_sum got %0d want 6", bus.out_sum); end
        applyStimulus(1'b0, 5'd0, 1'b0); tick();
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL bp_drain got %0d want 0", bus.out_valid); end
    endtask

    task automatic test_reset_midgroup();
        applyStimulus(1'b1, 5'd10, 1'b0); tick();
        applyStimulus(1'b1, 5'd20, 1'b0); tick();
        applyStimulus(1'b0, 5'd0, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_mid_valid got %0d want 0", bus.out_valid); end
        applyStimulus(1'b1, 5'd3, 1'b1); tick();
        checks++; if (bus.out_sum !== 7'd3) begin fails++; $display("[TB] FAIL rst_mid_sum got %0d want 3", bus.out_sum); end
        checks++; if (bus.out_count !== 3'd1) begin fails++; $display("[TB] FAIL rst_mid_count got %0d want 1", bus.out_count); end
        applyStimulus(1'b0, 5'd0, 1'b0); tick();
    endtask

    task automatic test_back_to_back();
        logic [4:0] beat [4] = '{5'd1, 5'd2, 5'd4, 5'd9};
        logic       last [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic       expV [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [6:0] expS [4] = '{7'd0, 7'd3, 7'd4, 7'd9};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, beat[i], last[i]);
            checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL b2b_ready[%0d] got %0d want 1", i, bus.in_ready); end
            tick();
            checks++; if (bus.out_valid !== expV[i]) begin fails++; $display("[TB] FAIL b2b_valid[%0d] got %0d want %0d", i, bus.out_valid, expV[i]); end
            if (expV[i]) begin
                checks++; if (bus.out_sum !== expS[i]) begin fails++; $display("[TB] FAIL b2b_sum[%0d] got %0d want %0d", i, bus.out_sum, expS[i]); end
            end
        end
        applyStimulus(1'b0, 5'd0, 1'b0); tick();
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL b2b_drain got %0d want 0", bus.out_valid); end
    endtask

    task automatic test_hold_reload();
        fires7 = 0;
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 5'd7, 1'b1); tick();
        applyStimulus(1'b1, 5'd8, 1'b1); tick();
        checks++; if (bus.out_sum !== 7'd7) begin fails++; $display("[TB] FAIL reload_hold_sum got %0d want 7", bus.out_sum); end
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("[TB] FAIL reload_valid got %0d want 1", bus.out_valid); end
        checks++; if (bus.out_sum !== 7'd8) begin fails++; $display("[TB] FAIL reload_sum got %0d want 8", bus.out_sum); end
        applyStimulus(1'b0, 5'd0, 1'b0); tick();
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reload_drain got %0d want 0", bus.out_valid); end
        checks++; if (fires7 !== 1) begin fails++; $display("[TB] FAIL reload_old_seen got %0d want 1", fires7); end
    endtask

    initial begin
        test_reset();
        test_group_last();
        test_max_close();
        test_backpressure();
        test_reset_midgroup();
        test_back_to_back();
        test_hold_reload();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
